// File: rtl/asrv32_dmem_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : asrv32_dmem_wb                                                  |
// | Brief    : Wishbone-style data memory slave. Word-addressed RAM with byte  |
// |            lane writes, programmable wait states and out-of-range error   |
// |            reporting. Returns raw 32-bit read data with a one-cycle ack.  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module asrv32_dmem_wb #(
    parameter int          MEMORY_DEPTH = 1024,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb_data,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [3:0]  i_wr_mask,
    output logic        o_ack_data,
    output logic [31:0] o_load_data,
    output logic        o_err,
    output logic        o_busy
);

    localparam int          c_idx_w     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [3:0]  c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] c_depth     = 32'(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;

    // Request fields captured at acceptance and held for the whole transaction
    logic                 r_we;
    logic                 r_oor;
    logic [c_idx_w-1:0]   r_index;
    logic [31:0]          r_data;
    logic [3:0]           r_mask;

    logic [31:0]          r_load_data;
    logic                 r_err;
    logic [31:0]          r_mem [MEMORY_DEPTH];

    logic [31:0]          w_offset;
    logic [31:0]          w_word;
    logic                 w_oor;
    logic [c_idx_w-1:0]   w_index;
    logic                 w_accept;
    logic                 w_enter_ack;
    logic                 w_cur_we;
    logic                 w_cur_oor;
    logic [c_idx_w-1:0]   w_cur_index;
    logic                 w_commit;
    logic                 w_unused;

    // Full 32-bit subtraction; addresses below the base are flagged separately
    // so a wrapped offset can never alias back into the array.
    assign w_offset = i_addr - BASE_ADDR;
    assign w_word   = {2'b00, w_offset[31:2]};
    assign w_oor    = (i_addr < BASE_ADDR) || (w_word >= c_depth);
    assign w_index  = w_word[c_idx_w-1:0];
    assign w_unused = &{1'b0, w_offset[1:0]};

    assign w_accept    = (r_state == S_IDLE) && i_stb_data;
    assign w_enter_ack = (w_state_next == S_ACK);

    // With zero wait states the ACK is entered straight from IDLE, so the
    // read must use the live request rather than the not-yet-latched copy.
    assign w_cur_we    = (r_state == S_IDLE) ? i_wr_en : r_we;
    assign w_cur_oor   = (r_state == S_IDLE) ? w_oor   : r_oor;
    assign w_cur_index = (r_state == S_IDLE) ? w_index : r_index;

    // Writes land at the edge that ends the ACK cycle
    assign w_commit = (r_state == S_ACK) && r_we && !r_oor;

    assign o_ack_data  = (r_state == S_ACK);
    assign o_busy      = (r_state != S_IDLE);
    assign o_load_data = r_load_data;
    assign o_err       = r_err;

    // State and wait counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and wait counter decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_stb_data) begin
                    if (WAIT_STATES > 0) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = c_wait_load;
                    end else begin
                        w_state_next = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture the request on acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_index <= '0;
            r_data  <= 32'd0;
            r_mask  <= 4'd0;
        end else if (w_accept) begin
            r_we    <= i_wr_en;
            r_oor   <= w_oor;
            r_index <= w_index;
            r_data  <= i_store_data;
            r_mask  <= i_wr_mask;
        end
    end

    // Response data and error, registered on entry into ACK and held otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load_data <= 32'd0;
            r_err       <= 1'b0;
        end else if (w_enter_ack) begin
            if (w_cur_oor) begin
                r_load_data <= 32'd0;
                r_err       <= 1'b1;
            end else begin
                r_err <= 1'b0;
                if (!w_cur_we) begin
                    r_load_data <= r_mem[w_cur_index];
                end
            end
        end
    end

    // Byte-lane RAM write; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (r_mask[k]) begin
                    r_mem[r_index][8*k +: 8] <= r_data[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asrv32_dmem_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_asrv32_dmem_wb                                               |
// | Brief    : Directed self-checking bench for asrv32_dmem_wb. Three          |
// |            instances: WAIT_STATES = 1, 3 and 0.                            |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_asrv32_dmem_wb;

    logic        clk;
    logic        rst_n;
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  mask  [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        err   [3];
    logic        busy  [3];

    int checks = 0;
    int errors = 0;
    int ack_cnt2 = 0;

    asrv32_dmem_wb #(.MEMORY_DEPTH(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_1000)) u_ws1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb_data(stb[0]), .i_wr_en(we[0]),
        .i_addr(addr[0]), .i_store_data(wdata[0]), .i_wr_mask(mask[0]),
        .o_ack_data(ack[0]), .o_load_data(rdata[0]), .o_err(err[0]), .o_busy(busy[0]));

    asrv32_dmem_wb #(.MEMORY_DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)) u_ws3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb_data(stb[1]), .i_wr_en(we[1]),
        .i_addr(addr[1]), .i_store_data(wdata[1]), .i_wr_mask(mask[1]),
        .o_ack_data(ack[1]), .o_load_data(rdata[1]), .o_err(err[1]), .o_busy(busy[1]));

    asrv32_dmem_wb #(.MEMORY_DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u_ws0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stb_data(stb[2]), .i_wr_en(we[2]),
        .i_addr(addr[2]), .i_store_data(wdata[2]), .i_wr_mask(mask[2]),
        .o_ack_data(ack[2]), .o_load_data(rdata[2]), .o_err(err[2]), .o_busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every ack pulse of the zero-wait instance to catch duplicates
    always @(negedge clk) if (ack[2] === 1'b1) ack_cnt2 <= ack_cnt2 + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One transaction: stb raised at a negedge (cycle 0), held until ack seen.
    // Inputs are scrambled one cycle after acceptance. lat = ack cycle, -1 on timeout.
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        stb[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; mask[k] = m;
        lat = -1; rd = 32'hx; e = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                we[k] = ~w; addr[k] = ~a; wdata[k] = ~d; mask[k] = ~m;
            end
            if (ack[k] === 1'b1) begin
                lat = c; rd = rdata[k]; e = err[k];
                break;
            end
        end
        stb[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; mask[k] = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stb[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; mask[k] = 4'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ack[k], err[k], busy[k], rdata[k]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: ack=%b err=%b busy=%b load=%h, required all 0",
                         k, ack[k], err[k], busy[k], rdata[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic e; int lat;
        txn(0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111, rd, e, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL basic_write: latency=%0d err=%b, required 2/0", lat, e);
        end
        txn(0, 1'b0, 32'h1000, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_read: latency=%0d err=%b data=%h, required 2/0/deadbeef", lat, e, rd);
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd; logic e; int lat;
        txn(0, 1'b1, 32'h1004, 32'h11223344, 4'b1111, rd, e, lat);
        txn(0, 1'b1, 32'h1004, 32'h00AB0000, 4'b0100, rd, e, lat);
        txn(0, 1'b0, 32'h1004, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (lat !== 2 || rd !== 32'h11AB3344) begin
            errors++;
            $display("FAIL byte_lane: latency=%0d data=%h, required 2/11ab3344", lat, rd);
        end
    endtask

    task automatic test_halfword();
        logic [31:0] rd; logic e; int lat;
        txn(0, 1'b1, 32'h1008, 32'hCAFEF00D, 4'b1111, rd, e, lat);
        txn(0, 1'b1, 32'h1008, 32'h12340000, 4'b1100, rd, e, lat);
        txn(0, 1'b0, 32'h1008, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (rd !== 32'h1234F00D) begin
            errors++;
            $display("FAIL halfword: data=%h, required 1234f00d", rd);
        end
        txn(0, 1'b1, 32'h1008, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL mask0_ack: latency=%0d err=%b, required 2/0", lat, e);
        end
        txn(0, 1'b0, 32'h1008, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (rd !== 32'h1234F00D) begin
            errors++;
            $display("FAIL mask0_nowrite: data=%h, required 1234f00d", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] oor_addr [2];
        oor_addr[0] = 32'h1000 + 32'd4 * 32'd1024;
        oor_addr[1] = 32'h0FFC;
        for (int i = 0; i < 2; i++) begin
            // Put a nonzero value on the load bus first so a zeroed result is meaningful
            txn(0, 1'b0, 32'h1000, 32'h0, 4'b0000, rd, e, lat);
            txn(0, 1'b0, oor_addr[i], 32'h0, 4'b0000, rd, e, lat);
            checks++;
            if (lat !== 2 || e !== 1'b1 || rd !== 32'd0) begin
                errors++;
                $display("FAIL oor_read @%h: latency=%0d err=%b data=%h, required 2/1/0", oor_addr[i], lat, e, rd);
            end
            txn(0, 1'b1, oor_addr[i], 32'h0BAD0BAD, 4'b1111, rd, e, lat);
            checks++;
            if (lat !== 2 || e !== 1'b1 || rd !== 32'd0) begin
                errors++;
                $display("FAIL oor_write @%h: latency=%0d err=%b data=%h, required 2/1/0", oor_addr[i], lat, e, rd);
            end
        end
        txn(0, 1'b0, 32'h1000, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL oor_word0_intact: err=%b data=%h, required 0/deadbeef", e, rd);
        end
        // Last in-range word
        txn(0, 1'b1, 32'h1FFC, 32'hA5A5_5A5A, 4'b1111, rd, e, lat);
        txn(0, 1'b0, 32'h1FFC, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL last_word: err=%b data=%h, required 0/a5a55a5a", e, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat; int acks;
        txn(1, 1'b1, 32'h1010, 32'h0BADF00D, 4'b1111, rd, e, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL ws3_latency: latency=%0d, required 4", lat);
        end
        @(negedge clk);
        stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1010; wdata[1] = 32'h55555555; mask[1] = 4'b1111;
        @(negedge clk);
        checks++;
        if (busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_before: busy=%b, required 1", busy[1]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        stb[1] = 1'b0; we[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b0 || ack[1] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: busy=%b ack=%b, required 0/0", busy[1], ack[1]);
        end
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_ack: acks=%0d, required 0", acks);
        end
        txn(1, 1'b0, 32'h1010, 32'h0, 4'b0000, rd, e, lat);
        checks++;
        if (lat !== 4 || rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL rst_mid_discard: latency=%0d data=%h, required 4/0badf00d", lat, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [16];
        logic [31:0] rd; logic e; int lat;
        int lat_bad = 0; int data_bad = 0; int ntx = 0; int start_acks;
        logic w; logic [31:0] d; logic [3:0] m; int idx;
        start_acks = ack_cnt2;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(2, 1'b1, 32'h1000 + 32'(4 * i), model[i], 4'b1111, rd, e, lat);
            ntx++;
            if (lat !== 1) lat_bad++;
        end
        for (int n = 0; n < 100; n++) begin
            idx = $urandom_range(15);
            w = 1'($urandom_range(1));
            d = $urandom;
            m = 4'($urandom_range(15));
            txn(2, w, 32'h1000 + 32'(4 * idx), d, m, rd, e, lat);
            ntx++;
            if (lat !== 1) lat_bad++;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end else if (rd !== model[idx] || e !== 1'b0) begin
                data_bad++;
                $display("FAIL b2b_read word%0d: data=%h err=%b, required %h/0", idx, rd, e, model[idx]);
            end
        end
        checks++;
        if (lat_bad !== 0) begin
            errors++;
            $display("FAIL b2b_latency: %0d transactions not acked 1 cycle after acceptance, required 0", lat_bad);
        end
        checks++;
        if (data_bad !== 0) begin
            errors++;
            $display("FAIL b2b_data: %0d read mismatches, required 0", data_bad);
        end
        @(negedge clk);
        checks++;
        if (busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, required 0", busy[2]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ack_cnt2 - start_acks !== ntx) begin
            errors++;
            $display("FAIL b2b_ack_count: acks=%0d, required %0d", ack_cnt2 - start_acks, ntx);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_lane();
        test_halfword();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
